// File: rtl/microcode_execution_sequencer_if.sv
// ============================================================================
// Module   : microcode_execution_sequencer_if
// Brief    : Handshake/bus bundle between the sequencer and its neighbours
//            (opcode translator, microcode ROM, program counter, memory).
//            Optional macro UOP_WATCHDOG_EN adds watchdog_fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface microcode_execution_sequencer_if #(
    parameter int UADDR_WIDTH  = 16,
    parameter int UCOUNT_WIDTH = 8
);
    logic                    enable;
    logic                    halt;
    logic [UADDR_WIDTH-1:0]  entry_address;
    logic                    instruction_finish;
    logic                    mem_ready;
    logic [UADDR_WIDTH-1:0]  microcode_address;
    logic                    microcode_rom_read_enable;
    logic                    instruction_latch;
    logic                    program_counter_enable;
    logic [UCOUNT_WIDTH-1:0] uop_count;
    logic [2:0]              state;
    logic                    halted;
`ifdef UOP_WATCHDOG_EN
    logic                    watchdog_fault;
`endif

    modport master (
`ifdef UOP_WATCHDOG_EN
        input  watchdog_fault,
`endif
        output enable, halt, entry_address, instruction_finish, mem_ready,
        input  microcode_address, microcode_rom_read_enable, instruction_latch,
        input  program_counter_enable, uop_count, state, halted
    );

    modport slave (
`ifdef UOP_WATCHDOG_EN
        output watchdog_fault,
`endif
        input  enable, halt, entry_address, instruction_finish, mem_ready,
        output microcode_address, microcode_rom_read_enable, instruction_latch,
        output program_counter_enable, uop_count, state, halted
    );
endinterface

`default_nettype wire

// File: rtl/microcode_execution_sequencer.sv
// ============================================================================
// Module   : microcode_execution_sequencer
// Brief    : Fetch / decode / execute FSM stepping the microcode address and
//            pulsing the PC when a micro-routine finishes.
//            Optional macro UOP_WATCHDOG_EN adds a per-instruction uop limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_execution_sequencer #(
    parameter int UADDR_WIDTH  = 16,
    parameter int FETCH_CYCLES = 1,
    parameter int UCOUNT_WIDTH = 8,
    parameter int MAX_UOPS     = 64
) (
    input  wire logic                      clock,
    input  wire logic                      reset_n,
    microcode_execution_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    localparam logic [3:0]              C_FETCH_LAST  = 4'(FETCH_CYCLES - 1);
    localparam logic [UCOUNT_WIDTH-1:0] C_UCOUNT_SAT  = '1;

    if (FETCH_CYCLES < 1 || FETCH_CYCLES > 15 || MAX_UOPS < 1) begin : g_param_check
        $error("microcode_execution_sequencer: FETCH_CYCLES must be 1..15 and MAX_UOPS >= 1");
    end

    state_t                  state_q, state_d;
    logic [3:0]              fetch_cnt_q, fetch_cnt_d;
    logic [UADDR_WIDTH-1:0]  uaddr_q, uaddr_d;
    logic [UCOUNT_WIDTH-1:0] ucount_q, ucount_d;
    logic [UCOUNT_WIDTH-1:0] ucount_inc_d;
    logic                    rom_re_q;
    logic                    halted_q;
`ifdef UOP_WATCHDOG_EN
    localparam logic [31:0]  C_MAX_UOPS = 32'(MAX_UOPS);
    logic                    wd_q, wd_d;
`endif

    assign ucount_inc_d = (ucount_q == C_UCOUNT_SAT) ? ucount_q : ucount_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        uaddr_d     = uaddr_q;
        ucount_d    = ucount_q;
`ifdef UOP_WATCHDOG_EN
        wd_d        = wd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // The fetch counter only advances on cycles the memory is ready.
                if (bus.mem_ready) begin
                    if (fetch_cnt_q == C_FETCH_LAST) begin
                        fetch_cnt_d = '0;
                        state_d     = ST_DECODE;
                    end else begin
                        fetch_cnt_d = fetch_cnt_q + 4'd1;
                    end
                end
            end
            ST_DECODE: begin
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else begin
                    uaddr_d  = bus.entry_address;
                    ucount_d = '0;
                    state_d  = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (bus.mem_ready) begin
                    ucount_d = ucount_inc_d;
                    if (bus.instruction_finish) begin
                        state_d = bus.enable ? ST_FETCH : ST_IDLE;
                    end else begin
                        uaddr_d = uaddr_q + 1'b1;
`ifdef UOP_WATCHDOG_EN
                        if (32'(ucount_inc_d) >= C_MAX_UOPS) begin
                            state_d = ST_HALTED;
                            wd_d    = 1'b1;
                        end
`endif
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fetch_cnt_q <= '0;
            uaddr_q     <= '0;
            ucount_q    <= '0;
            rom_re_q    <= 1'b0;
            halted_q    <= 1'b0;
`ifdef UOP_WATCHDOG_EN
            wd_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            uaddr_q     <= uaddr_d;
            ucount_q    <= ucount_d;
            rom_re_q    <= (state_d == ST_EXECUTE);
            halted_q    <= (state_d == ST_HALTED);
`ifdef UOP_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Pulses must coincide with the ready cycle that completes them, so they
    // are decoded from the state register and the live handshake inputs.
    assign bus.instruction_latch         = (state_q == ST_FETCH) && bus.mem_ready &&
                                           (fetch_cnt_q == C_FETCH_LAST);
    assign bus.program_counter_enable    = (state_q == ST_EXECUTE) && bus.mem_ready &&
                                           bus.instruction_finish;
    assign bus.microcode_address         = uaddr_q;
    assign bus.microcode_rom_read_enable = rom_re_q;
    assign bus.uop_count                 = ucount_q;
    assign bus.state                     = state_q;
    assign bus.halted                    = halted_q;
`ifdef UOP_WATCHDOG_EN
    assign bus.watchdog_fault            = wd_q;
`endif

endmodule

`default_nettype wire

// File: doc/microcode_execution_sequencer.md
Name: microcode_execution_sequencer

Overview:
Parametrised successor to the execution_driver / microcode-sequencer counter pair. It merges both into one FSM that fetches an instruction, loads the microcode entry point, steps the microcode address, and advances the program counter when a micro-routine finishes. Adds a memory-wait handshake, a multi-cycle fetch latency, clean halt/stop semantics and a per-instruction micro-op count. Sits between the opcode-translator ROM (entry address in), the microcode ROM (address out) and the program counter (enable out).

Parameters:
UADDR_WIDTH, 16, microcode address width
FETCH_CYCLES, 1, program RAM read latency in cycles (legal range 1..15)
UCOUNT_WIDTH, 8, width of the per-instruction micro-op counter
MAX_UOPS, 64, watchdog limit in micro-ops per instruction (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  run permit
halt  in  1  halt opcode detected (from halt_check), sampled in DECODE only
entry_address  in  UADDR_WIDTH  micro-routine start address from the opcode translator
instruction_finish  in  1  microcode control line marking the last micro-op of a routine
mem_ready  in  1  memory ready; low stalls FETCH and EXECUTE
microcode_address  out  UADDR_WIDTH  microcode ROM address
microcode_rom_read_enable  out  1  high only in EXECUTE
instruction_latch  out  1  one-cycle pulse that latches the fetched word into the datapath
program_counter_enable  out  1  one-cycle pulse that advances the PC
uop_count  out  UCOUNT_WIDTH  micro-ops retired in the current instruction
state  out  3  encoded state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALTED=4
halted  out  1  high while in HALTED

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - All outputs 0, including microcode_address=0, uop_count=0 and the fetch counter.
  - Reset asserted mid-instruction aborts immediately; no PC pulse is emitted.
- IDLE: enable=1 -> FETCH next cycle. Otherwise stay.
- FETCH:
  - An internal fetch counter increments on each cycle with mem_ready=1 and holds when mem_ready=0.
  - On the FETCH_CYCLES-th ready cycle: instruction_latch=1 for that cycle, counter clears, -> DECODE.
- DECODE (always exactly 1 cycle):
  - halt=1 -> HALTED. microcode_address is unchanged and no PC pulse is emitted.
  - Otherwise: microcode_address <= entry_address, uop_count <= 0, -> EXECUTE.
- EXECUTE:
  - microcode_rom_read_enable=1.
  - mem_ready=0: microcode_address and uop_count hold. instruction_finish is ignored.
  - mem_ready=1 and instruction_finish=0: microcode_address increments by 1, wrapping from 2^UADDR_WIDTH-1 to 0. uop_count increments, saturating at all-ones.
  - mem_ready=1 and instruction_finish=1: program_counter_enable=1 for this cycle and uop_count increments. Next state is FETCH if enable=1, else IDLE.
  - enable dropping mid-routine does not abort; the current routine completes first.
- HALTED: sticky. halted=1 and all pulses are 0. Exit is by reset only.
- Latency, single-cycle routine, FETCH_CYCLES=1, mem_ready=1: the instruction takes 3 cycles (FETCH, DECODE, EXECUTE). PC pulse falls in cycle 3; the next FETCH starts in cycle 4.
- Simultaneous events:
  - halt outside DECODE has no effect.
  - instruction_finish with mem_ready=0 is ignored.

Optional Feature:
- Macro: UOP_WATCHDOG_EN.
- Defined:
  - Adds output port watchdog_fault (1 bit, reset 0).
  - If uop_count reaches MAX_UOPS in EXECUTE without instruction_finish, the FSM enters HALTED and sets watchdog_fault=1.
  - No PC pulse is emitted. The fault is sticky until reset.
- Not defined: the port is absent and there is no micro-op limit.

Test Plan:
- Reset, then enable=1, entry_address=0x0010, instruction_finish high on the 3rd micro-op, FETCH_CYCLES=1 -> microcode_address goes 0x10, 0x11, 0x12; one program_counter_enable pulse; uop_count=3; back to FETCH.
- FETCH_CYCLES=3 with mem_ready low for 2 cycles inside FETCH -> instruction_latch pulses exactly once, 5 cycles after entering FETCH.
- halt=1 during DECODE -> state=4, halted=1, no PC pulse, microcode_rom_read_enable stays 0 forever; a later halt deassert changes nothing.
- entry_address=0xFFFF, finish on the 2nd micro-op -> microcode_address goes 0xFFFF then 0x0000; PC pulse on the 0x0000 cycle.
- enable dropped mid-EXECUTE, then reset_n pulsed low mid-EXECUTE -> first case completes the routine and goes to IDLE with one PC pulse; second case gives all outputs 0 immediately, asynchronously.
- UOP_WATCHDOG_EN with MAX_UOPS=4 and instruction_finish never asserted -> after the 4th micro-op, watchdog_fault=1, halted=1 and no PC pulse.
